// File: rtl/stream_output_handler_if.sv
// Hit-result, query-end and stream-output handshake bundle of the stream output handler.
// The engine/stream side uses the master modport; the handler uses the slave modport.
interface stream_output_handler_if #(
  parameter int SCORE_WIDTH   = 16,
  parameter int REF_POS_WIDTH = 25
);
  logic [SCORE_WIDTH-1:0]   result_score_in;
  logic [REF_POS_WIDTH-1:0] result_ref_pos_in;
  logic                     result_valid_in;
  logic                     result_rdy_out;
  logic                     query_end_valid_in;
  logic                     query_end_rdy_out;
  logic [127:0]             so_data;
  logic                     so_valid;
  logic                     so_rdy;

  modport master (
    output result_score_in, result_ref_pos_in, result_valid_in,
    output query_end_valid_in, so_rdy,
    input  result_rdy_out, query_end_rdy_out, so_data, so_valid
  );

  modport slave (
    input  result_score_in, result_ref_pos_in, result_valid_in,
    input  query_end_valid_in, so_rdy,
    output result_rdy_out, query_end_rdy_out, so_data, so_valid
  );
endinterface

// File: rtl/stream_output_handler.sv
// Packs engine hits two per 128-bit stream word and closes every query with a
// trailer word holding the query's hit count and index.
module stream_output_handler #(
  parameter int SCORE_WIDTH    = 16,
  parameter int REF_POS_WIDTH  = 25,
  parameter int QUERY_ID_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  stream_output_handler_if.slave bus
);

  typedef enum logic [2:0] {
    COLLECT0     = 3'd0,
    COLLECT1     = 3'd1,
    SEND_DATA    = 3'd2,
    SEND_PARTIAL = 3'd3,
    SEND_TRAILER = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [63:0]               slot0_q, slot0_d;
  logic [31:0]               hit_cnt_q, hit_cnt_d;
  logic [QUERY_ID_WIDTH-1:0] query_idx_q, query_idx_d;
  logic [127:0]              so_data_q, so_data_d;
  logic                      so_valid_q, so_valid_d;

  logic                      collecting_s;
  logic                      hit_acc_s;
  logic                      qend_acc_s;
  logic [63:0]               new_slot_s;
  logic [31:0]               hit_cnt_inc_s;
  logic [127:0]              trailer_s;

  function automatic logic [63:0] make_slot(
    input logic [SCORE_WIDTH-1:0]   score,
    input logic [REF_POS_WIDTH-1:0] ref_pos
  );
    logic [63:0] slot;
    slot                        = 64'd0;
    slot[REF_POS_WIDTH-1:0]     = ref_pos;
    slot[32 +: SCORE_WIDTH]     = score;
    slot[63]                    = 1'b1;
    return slot;
  endfunction

  function automatic logic [127:0] make_trailer(
    input logic [31:0]               cnt,
    input logic [QUERY_ID_WIDTH-1:0] idx
  );
    logic [127:0] word;
    word                        = 128'd0;
    word[31:0]                  = cnt;
    word[32 +: QUERY_ID_WIDTH]  = idx;
    return word;
  endfunction

  // A hit always wins over a query end presented in the same cycle.
  assign collecting_s          = (state_q == COLLECT0) || (state_q == COLLECT1);
  assign hit_acc_s             = collecting_s && bus.result_valid_in;
  assign qend_acc_s            = collecting_s && !bus.result_valid_in && bus.query_end_valid_in;
  assign new_slot_s            = make_slot(bus.result_score_in, bus.result_ref_pos_in);
  assign hit_cnt_inc_s         = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q : hit_cnt_q + 32'd1;
  assign trailer_s             = make_trailer(hit_cnt_q, query_idx_q);

  assign bus.result_rdy_out    = collecting_s;
  assign bus.query_end_rdy_out = collecting_s && !bus.result_valid_in;
  assign bus.so_data           = so_data_q;
  assign bus.so_valid          = so_valid_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT0;
      slot0_q     <= 64'd0;
      hit_cnt_q   <= 32'd0;
      query_idx_q <= {QUERY_ID_WIDTH{1'b0}};
      so_data_q   <= 128'd0;
      so_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot0_q     <= slot0_d;
      hit_cnt_q   <= hit_cnt_d;
      query_idx_q <= query_idx_d;
      so_data_q   <= so_data_d;
      so_valid_q  <= so_valid_d;
    end
  end

  // Next-state and output-word selection.
  always_comb begin
    state_d     = state_q;
    slot0_d     = slot0_q;
    query_idx_d = query_idx_q;
    so_data_d   = so_data_q;
    so_valid_d  = so_valid_q;
    if (hit_acc_s) begin
      hit_cnt_d = hit_cnt_inc_s;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end

    case (state_q)
      COLLECT0: begin
        if (hit_acc_s) begin
          slot0_d = new_slot_s;
          state_d = COLLECT1;
        end else if (qend_acc_s) begin
          so_data_d  = trailer_s;
          so_valid_d = 1'b1;
          state_d    = SEND_TRAILER;
        end else begin
          state_d = COLLECT0;
        end
      end
      COLLECT1: begin
        if (hit_acc_s) begin
          so_data_d  = {new_slot_s, slot0_q};
          so_valid_d = 1'b1;
          state_d    = SEND_DATA;
        end else if (qend_acc_s) begin
          so_data_d  = {64'd0, slot0_q};
          so_valid_d = 1'b1;
          state_d    = SEND_PARTIAL;
        end else begin
          state_d = COLLECT1;
        end
      end
      SEND_DATA: begin
        if (bus.so_rdy) begin
          so_valid_d = 1'b0;
          state_d    = COLLECT0;
        end else begin
          state_d = SEND_DATA;
        end
      end
      SEND_PARTIAL: begin
        // Trailer follows the partial word back to back, valid stays high.
        if (bus.so_rdy) begin
          so_data_d = trailer_s;
          state_d   = SEND_TRAILER;
        end else begin
          state_d = SEND_PARTIAL;
        end
      end
      SEND_TRAILER: begin
        if (bus.so_rdy) begin
          so_valid_d  = 1'b0;
          hit_cnt_d   = 32'd0;
          query_idx_d = query_idx_q + QUERY_ID_WIDTH'(1'b1);
          state_d     = COLLECT0;
        end else begin
          state_d = SEND_TRAILER;
        end
      end
      default: begin
        so_valid_d = 1'b0;
        state_d    = COLLECT0;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_output_handler.sv
// Self-checking bench for stream_output_handler: directed scenarios plus random
// queries compared against a query-level packing model.
module tb_stream_output_handler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_output_handler_if b  ();
  stream_output_handler_if b2 ();

  stream_output_handler dut (.clk(clk), .rst(rst), .bus(b));
  stream_output_handler #(.QUERY_ID_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int           checks = 0;
  int           errors = 0;
  logic [127:0] obs_q[$];
  logic [127:0] exp_q[$];
  logic [63:0]  cur_slots[$];
  int unsigned  qidx_m = 0;
  bit           rnd_mode = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] slot_m(input logic [15:0] s, input logic [24:0] p);
    return {1'b1, 15'd0, s, 1'b0, 6'd0, p};
  endfunction

  function automatic logic [127:0] trailer_m(input int unsigned cnt, input int unsigned idx,
                                             input int unsigned modulus);
    logic [127:0] t;
    t = 128'(cnt);
    t = t | (128'(idx % modulus) << 32);
    return t;
  endfunction

  // Model: pack the query's hits pairwise, odd leftover as a partial word, then the trailer.
  function automatic void end_query();
    int n;
    n = cur_slots.size();
    for (int i = 0; i + 1 < n; i += 2) exp_q.push_back({cur_slots[i+1], cur_slots[i]});
    if (n % 2 == 1) exp_q.push_back({64'd0, cur_slots[n-1]});
    exp_q.push_back(trailer_m(n, qidx_m, 65536));
    qidx_m = (qidx_m + 1) % 65536;
    cur_slots.delete();
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst === 1'b0 && b.so_valid === 1'b1 && b.so_rdy === 1'b1) obs_q.push_back(b.so_data);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_mode) b.so_rdy = ($urandom_range(0, 9) < 7);
  end

  task automatic send_hit(input logic [15:0] s, input logic [24:0] p);
    int n;
    n = 0;
    b.result_score_in   = s;
    b.result_ref_pos_in = p;
    b.result_valid_in   = 1'b1;
    @(negedge clk);
    while (b.result_rdy_out !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("hit_accept_in_time", 128'(n < 300), 128'd1);
    @(posedge clk);
    #1;
    b.result_valid_in = 1'b0;
    cur_slots.push_back(slot_m(s, p));
  endtask

  task automatic qend_handshake();
    int n;
    n = 0;
    b.query_end_valid_in = 1'b1;
    @(negedge clk);
    while (b.query_end_rdy_out !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("qend_accept_in_time", 128'(n < 300), 128'd1);
    @(posedge clk);
    #1;
    b.query_end_valid_in = 1'b0;
  endtask

  task automatic send_qend();
    qend_handshake();
    end_query();
  endtask

  task automatic drain(input string tag);
    int n;
    logic [127:0] o;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_in_time"}, 128'(n < 3000), 128'd1);
    while (exp_q.size() > 0) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 128'hx;
      chk({tag, "_word"}, o, exp_q.pop_front());
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_no_extra_words"}, 128'(obs_q.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] held;
    logic [15:0]  s;
    logic [24:0]  p;
    int           n;
    int           nh;

    rst = 1'b1;
    b.result_score_in = 16'd0; b.result_ref_pos_in = 25'd0; b.result_valid_in = 1'b0;
    b.query_end_valid_in = 1'b0; b.so_rdy = 1'b0;
    b2.result_score_in = 16'd0; b2.result_ref_pos_in = 25'd0; b2.result_valid_in = 1'b0;
    b2.query_end_valid_in = 1'b0; b2.so_rdy = 1'b1;
    #1;
    chk("reset_so_valid", 128'(b.so_valid), 128'd0);
    chk("reset_so_data", b.so_data, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("idle_result_rdy", 128'(b.result_rdy_out), 128'd1);
    chk("idle_qend_rdy", 128'(b.query_end_rdy_out), 128'd1);

    // Two hits, one full word, then trailer with two hits.
    b.so_rdy = 1'b1;
    send_hit(16'h0012, 25'h0000100);
    send_hit(16'h0034, 25'h1ABCDEF);
    chk("t1_valid_after_2nd_hit", 128'(b.so_valid), 128'd1);
    chk("t1_data_word", b.so_data, 128'h80000034_01ABCDEF_80000012_00000100);
    send_qend();
    chk("t1_trailer_valid", 128'(b.so_valid), 128'd1);
    chk("t1_trailer", b.so_data, 128'h2);
    drain("t1");

    // Three hits: full, partial, trailer back to back.
    for (int i = 0; i < 3; i++) send_hit(16'($urandom), 25'($urandom));
    send_qend();
    chk("t3_partial_valid", 128'(b.so_valid), 128'd1);
    chk("t3_partial_bit127", 128'(b.so_data[127]), 128'd0);
    @(posedge clk);
    #1;
    chk("t3_trailer_adjacent", 128'(b.so_valid), 128'd1);
    chk("t3_trailer", b.so_data, trailer_m(3, 1, 65536));
    drain("t3");

    // Queries with zero hits.
    send_qend();
    send_qend();
    drain("t_zero");

    // Backpressure in SEND_DATA while a hit waits.
    b.so_rdy = 1'b0;
    send_hit(16'h1111, 25'h0000222);
    send_hit(16'h3333, 25'h0000444);
    held = b.so_data;
    chk("t4_word", held, {slot_m(16'h3333, 25'h0000444), slot_m(16'h1111, 25'h0000222)});
    b.result_score_in = 16'h5555; b.result_ref_pos_in = 25'h0000666; b.result_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_rdy_low", 128'(b.result_rdy_out), 128'd0);
      chk("t4_data_stable", b.so_data, held);
      chk("t4_valid_stable", 128'(b.so_valid), 128'd1);
    end
    @(posedge clk);
    #1;
    b.result_valid_in = 1'b0;
    b.so_rdy = 1'b1;
    send_hit(16'h7777, 25'h0000888);
    send_qend();
    drain("t4");

    // Hit and query end together: only the hit is taken.
    s = 16'hABCD; p = 25'h0123456;
    b.result_score_in = s; b.result_ref_pos_in = p;
    b.result_valid_in = 1'b1; b.query_end_valid_in = 1'b1;
    @(negedge clk);
    chk("t5_qend_rdy_low", 128'(b.query_end_rdy_out), 128'd0);
    chk("t5_result_rdy_high", 128'(b.result_rdy_out), 128'd1);
    @(posedge clk);
    #1;
    b.result_valid_in = 1'b0;
    cur_slots.push_back(slot_m(s, p));
    chk("t5_no_output_yet", 128'(b.so_valid), 128'd0);
    send_qend();
    drain("t5");

    // Random queries under random backpressure.
    rnd_mode = 1'b1;
    for (int q = 0; q < 20; q++) begin
      nh = $urandom_range(0, 5);
      for (int h = 0; h < nh; h++) begin
        send_hit(16'($urandom), 25'($urandom));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_qend();
    end
    drain("t_rand");
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;

    // Reset while a partial word is pending.
    b.so_rdy = 1'b0;
    send_hit(16'h0F0F, 25'h00F0F0F);
    qend_handshake();
    chk("t6_partial_pending", 128'(b.so_valid), 128'd1);
    rst = 1'b1;
    #1;
    chk("t6_valid_cleared_async", 128'(b.so_valid), 128'd0);
    chk("t6_data_cleared_async", b.so_data, 128'd0);
    cur_slots.delete();
    qidx_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    b.so_rdy = 1'b1;
    send_qend();
    chk("t6_trailer_restart", b.so_data, 128'd0);
    drain("t6");

    // Narrow query index wraps after four queries.
    for (int i = 0; i < 5; i++) begin
      n = 0;
      b2.query_end_valid_in = 1'b1;
      @(negedge clk);
      while (b2.query_end_rdy_out !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("qw2_accept_in_time", 128'(n < 300), 128'd1);
      @(posedge clk);
      #1;
      b2.query_end_valid_in = 1'b0;
      chk("qw2_valid", 128'(b2.so_valid), 128'd1);
      chk("qw2_trailer", b2.so_data, trailer_m(0, i, 4));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
